freq_gen_mc: RTL and testbench
==============================

Name: freq_gen_mc

Overview:
- Multi-channel programmable frequency generator; successor to the single-channel freq_gen.
- Derives NumChannels independent divided outputs from one input clock.
- Each channel has its own divisor and waveform mode (50% square or single-cycle pulse).
- Reconfiguration through a valid/ready port takes effect only at a period boundary (glitch-free); a global sync restart phase-aligns all channels.

Parameters:
- DataWidth, 8, width of each divisor.
- NumChannels, 4, number of output channels (>=1).
- ChanW, $clog2(NumChannels) with minimum 1 (derived localparam), width of cfg_chan.

Ports:
- clk_in  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous, active-low.
- sync_restart  input  1  one-cycle pulse; restarts all channels in phase.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept, combinational: high unless the addressed channel already has a pending config.
- cfg_chan  input  ChanW  target channel.
- cfg_div  input  DataWidth  new divisor D.
- cfg_mode  input  1  0 = SQUARE, 1 = PULSE.
- cfg_err  output  1  one-cycle pulse when a write to cfg_chan >= NumChannels is accepted.
- cfg_pending  output  NumChannels  per-channel shadow config waiting to be applied.
- clk_out  output  NumChannels  registered divided outputs.
- period_tick  output  NumChannels  one-cycle pulse at each period boundary of a channel.

Behaviour:
- Reset (async, rst_n low): every channel D=0, mode SQUARE, cnt=0. clk_out=0, period_tick=0, cfg_pending=0, cfg_err=0.
- Handshake: accept = cfg_valid && cfg_ready.
  - On accept, {cfg_div, cfg_mode} goes to the channel's shadow register and cfg_pending[ch]=1 from the next cycle.
  - Out-of-range channel: cfg_ready=1, write dropped, cfg_err pulses the next cycle.
- D=0 (stopped): clk_out low, no ticks, cnt held at 0.
- SQUARE mode, D>=1:
  - cnt counts 0..D-1 and wraps.
  - clk_out toggles on the cycle after cnt==D-1.
  - Period is 2*D cycles; first phase after reset or restart is low.
- PULSE mode, D>=1:
  - cnt counts 0..D-1.
  - clk_out=1 for exactly the cycle after cnt==D-1.
  - Period is D cycles; D=1 gives a constant 1.
- Period boundary (cycle B):
  - SQUARE: cnt==D-1 and clk_out==1.
  - PULSE: cnt==D-1.
  - period_tick is asserted during B.
- Apply rules:
  - If pending at B: the new D/mode load, cnt=0, clk_out=0 in B+1, and pending clears.
  - If the channel is stopped (D=0) and pending: apply on the cycle after pending is set.
  - A config accepted during B is not applied at that B; it waits for the next boundary.
- sync_restart:
  - Next cycle, all channels: cnt=0, clk_out=0, period_tick=0.
  - Any pending config applies immediately and its pending bit clears.
  - A write accepted in the same cycle as sync_restart stays pending.
- Changing D to 0 via config stops the channel glitch-free at the boundary.
- Counter width is DataWidth; no overflow possible since cnt<D<=2^DataWidth-1.
- Mid-operation rst_n assertion returns everything to reset values immediately. The first post-reset edge behaves like post-reset.

Decomposition:
- Package freq_gen_pkg holds:
  - typedef enum logic {SQUARE, PULSE} wave_mode_t;
  - typedef struct {div, mode} chan_cfg_t, parameterised via DataWidth in the module.
  - function chan_w(n) returning max(1, $clog2(n)).
- Sub-module freq_gen_chan, one per channel via generate, contains:
  - active cfg, shadow cfg, pending bit, counter, output register and tick logic.
  - Inputs: wr_en, wr_cfg, sync_restart.
- Top level holds decode, cfg_ready mux, cfg_err register and the generate loop.

Test Plan:
- Reset, then write ch0 D=3 SQUARE while stopped -> applied 1 cycle after pending. clk_out[0] low 3, high 3, period 6. period_tick[0] every 6 cycles on the last high cycle.
- Ch1 D=4 PULSE -> clk_out[1] high one cycle every 4. Then write D=1 -> after the next boundary clk_out[1] constant 1.
- Ch0 running D=3, write D=5 mid-period -> old 6-cycle period completes with no short or long pulse, then 10-cycle periods. cfg_ready for ch0 low while pending.
- Second write to ch0 while pending -> cfg_ready=0, write held until the boundary. Write to ch2 in the same period is accepted.
- cfg_chan=5 with NumChannels=4 -> cfg_err pulses once, no channel state changes.
- Ch0 D=2 and ch1 D=3 running, pulse sync_restart -> next cycle both clk_out=0 and cnt=0. Rising edges then align at cycles 2 and 3. rst_n low mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared waveform mode type and channel-select width helper.
package freq_gen_pkg;
  typedef enum logic {SQUARE, PULSE} wave_mode_t;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/freq_gen_chan.sv
// freq_gen_chan: one divided output with shadow config applied at period boundaries.
module freq_gen_chan
  import freq_gen_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               sync_restart,
  input  logic               wr_en,
  input  logic [DataWidth:0] wr_cfg,
  output logic               pending,
  output logic               clk_out,
  output logic               period_tick
);
  typedef struct packed {
    logic [DataWidth-1:0] div;
    wave_mode_t           mode;
  } chan_cfg_t;
  chan_cfg_t act, shd;
  logic [DataWidth-1:0] cnt;
  logic stopped, last, apply;
  assign stopped     = act.div == '0;
  assign last        = !stopped && cnt == act.div - DataWidth'(1);
  assign period_tick = last && (act.mode == PULSE || clk_out);
  assign apply       = pending && (sync_restart || stopped || period_tick);
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      act     <= '0;
      shd     <= '0;
      pending <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      pending <= wr_en || (pending && !apply);
      if (wr_en) shd <= chan_cfg_t'(wr_cfg);
      if (apply) begin
        act     <= shd;
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (sync_restart || stopped) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else begin
        cnt     <= last ? '0 : cnt + DataWidth'(1);
        clk_out <= act.mode == PULSE ? last : clk_out ^ last;
      end
    end
  end
endmodule

// File: rtl/freq_gen_mc.sv
// freq_gen_mc: multi-channel programmable frequency generator with
// valid/ready reconfiguration and a global phase-aligning restart.
module freq_gen_mc
  import freq_gen_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int NumChannels = 4,
  localparam int ChanW      = chan_w(NumChannels)
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   sync_restart,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ChanW-1:0]       cfg_chan,
  input  logic [DataWidth-1:0]   cfg_div,
  input  logic                   cfg_mode,
  output logic                   cfg_err,
  output logic [NumChannels-1:0] cfg_pending,
  output logic [NumChannels-1:0] clk_out,
  output logic [NumChannels-1:0] period_tick
);
  logic in_range, accept;
  assign in_range  = int'(cfg_chan) < NumChannels;
  assign cfg_ready = in_range ? !cfg_pending[cfg_chan] : 1'b1;
  assign accept    = cfg_valid && cfg_ready;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= accept && !in_range;
  end
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    freq_gen_chan #(.DataWidth(DataWidth)) u_chan (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .sync_restart(sync_restart),
      .wr_en       (accept && cfg_chan == ChanW'(c)),
      .wr_cfg      ({cfg_div, cfg_mode}),
      .pending     (cfg_pending[c]),
      .clk_out     (clk_out[c]),
      .period_tick (period_tick[c])
    );
  end
endmodule

// File: tb/tb_freq_gen_mc.sv
// tb_freq_gen_mc: directed plus randomized checks against an elapsed-time reference model.
module tb_freq_gen_mc;
  localparam int DW = 8;
  localparam int N  = 5;
  localparam int CW = 3;
  logic clk_in = 1'b0, rst_n = 1'b0, sync_restart = 1'b0, cfg_valid = 1'b0, cfg_mode = 1'b0;
  logic [CW-1:0] cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic cfg_ready, cfg_err;
  logic [N-1:0] cfg_pending, clk_out, period_tick;
  int checks = 0, errors = 0;
  int md[N], mm[N], mt[N], mp[N], sd[N], sm[N];
  int merr;

  freq_gen_mc #(.DataWidth(DW), .NumChannels(N)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sync_restart(sync_restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .cfg_pending(cfg_pending), .clk_out(clk_out), .period_tick(period_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_tick(input int c);
    if (md[c] == 0) return 0;
    return mm[c] == 0 ? (mt[c] % (2 * md[c])) == 2 * md[c] - 1 : (mt[c] % md[c]) == md[c] - 1;
  endfunction

  function automatic bit m_out(input int c);
    if (md[c] == 0) return 0;
    return mm[c] == 0 ? ((mt[c] / md[c]) % 2) == 1 : (mt[c] > 0 && mt[c] % md[c] == 0);
  endfunction

  function automatic bit m_ready();
    return int'(cfg_chan) >= N ? 1'b1 : mp[cfg_chan] == 0;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      md[c] = 0; mm[c] = 0; mt[c] = 0; mp[c] = 0; sd[c] = 0; sm[c] = 0;
    end
    merr = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] eo, et, ep;
    for (int c = 0; c < N; c++) begin
      eo[c] = m_out(c); et[c] = m_tick(c); ep[c] = mp[c] != 0;
    end
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(eo));
    chk({tag, ".period_tick"}, 32'(period_tick), 32'(et));
    chk({tag, ".cfg_pending"}, 32'(cfg_pending), 32'(ep));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(merr));
  endtask

  // One clock: check handshake before the edge, advance the model, check after.
  task automatic cyc();
    bit acc, tk, ap;
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    acc = cfg_valid && m_ready();
    @(posedge clk_in);
    for (int c = 0; c < N; c++) begin
      tk = m_tick(c);
      ap = mp[c] != 0 && (sync_restart || md[c] == 0 || tk);
      if (ap) begin
        md[c] = sd[c]; mm[c] = sm[c]; mt[c] = 0;
      end else if (sync_restart || md[c] == 0) mt[c] = 0;
      else mt[c]++;
      if (acc && int'(cfg_chan) == c) begin
        mp[c] = 1; sd[c] = int'(cfg_div); sm[c] = int'(cfg_mode);
      end else if (ap) mp[c] = 0;
    end
    merr = int'(acc && int'(cfg_chan) >= N);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int ch, input int dv, input bit md_);
    cfg_valid = 1'b1; cfg_chan = CW'(ch); cfg_div = DW'(dv); cfg_mode = md_;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_reset();
    #1 compare_all("async_reset");
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk_in);
    #1 compare_all("reset");
    chk("reset.cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    idle(2);
    wr(0, 3, 1'b0);
    chk("ch0_pending_set", 32'(cfg_pending[0]), 32'd1);
    idle(20);
    wr(1, 4, 1'b1);
    idle(12);
    wr(1, 1, 1'b1);
    idle(8);
    chk("ch1_const_high", 32'(clk_out[1]), 32'd1);
    idle(2);
    wr(0, 5, 1'b0);
    cfg_chan = '0;
    #1 chk("ch0_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_div = 8'd7;
    for (int i = 0; i < 40 && cfg_valid; i++) begin
      if (i == 1) begin
        cfg_valid = 1'b0; wr(2, 2, 1'b0);
        cfg_valid = 1'b1; cfg_chan = '0; cfg_div = 8'd7;
      end
      if (cfg_ready) begin cyc(); cfg_valid = 1'b0; end
      else cyc();
    end
    chk("held_write_accepted", 32'(cfg_valid), 32'd0);
    idle(40);
    wr(5, 9, 1'b0);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    idle(1);
    chk("cfg_err_single", 32'(cfg_err), 32'd0);
    wr(0, 2, 1'b0);
    wr(1, 3, 1'b0);
    idle(25);
    sync_restart = 1'b1;
    cyc();
    sync_restart = 1'b0;
    chk("restart_low", 32'(clk_out[1:0]), 32'd0);
    idle(3);
    chk("ch0_high_after_restart", 32'(clk_out[0]), 32'd1);
    idle(4);
    do_reset();
    chk("reset_mid.clk_out", 32'(clk_out), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      cfg_valid    = ($urandom % 3) == 0;
      cfg_chan     = CW'($urandom % 8);
      cfg_div      = DW'($urandom % 7);
      cfg_mode     = 1'($urandom % 2);
      sync_restart = ($urandom % 40) == 0;
      if (i % 700 == 699) do_reset();
      cyc();
    end
    cfg_valid = 1'b0; sync_restart = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
